// File: rtl/multiplicador_algoritmico.sv
// rtl/multiplicador_algoritmico.sv - sequential signed shift-add multiplier, NUM = COC*DEN + RES
//
// Rebuilds a dividend from divider results using the START/DONE handshake of
// Divisor_Algoritmico. A single multiplication takes tamanyo+1 clock edges,
// whatever the operand values.
//
// Optional feature macro: MULT_OVF_EN (adds the OVF output).
//
// Ports:
//   CLK    in   rising-edge clock
//   RSTn   in   asynchronous active-low reset
//   START  in   start request, sampled only in IDLE
//   COC    in   [tamanyo] signed quotient operand
//   DEN    in   [tamanyo] signed divisor operand
//   RES    in   [tamanyo] signed remainder addend
//   NUM    out  [tamanyo] low tamanyo bits of COC*DEN+RES, registered
//   DONE   out  one-cycle completion pulse, registered
//   OVF    out  (MULT_OVF_EN only) full-precision result out of signed range

module multiplicador_algoritmico #(
    parameter int tamanyo = 32
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               START,
    input  logic [tamanyo-1:0] COC,
    input  logic [tamanyo-1:0] DEN,
    input  logic [tamanyo-1:0] RES,
    output logic [tamanyo-1:0] NUM,
    output logic               DONE
`ifdef MULT_OVF_EN
    ,
    output logic               OVF
`endif
);

    localparam int W  = tamanyo;
    localparam int AW = 2 * W + 2;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CORR
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] mcand;
    logic [W:0]    mplier;
    logic [W-1:0]  res_r;
    logic          sign_r;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    // One extra magnitude bit keeps |-2^(W-1)| exact.
    logic [W:0] coc_ext, den_ext, coc_mag, den_mag;
    assign coc_ext = {COC[W-1], COC};
    assign den_ext = {DEN[W-1], DEN};
    assign coc_mag = COC[W-1] ? ((W+1)'(0) - coc_ext) : coc_ext;
    assign den_mag = DEN[W-1] ? ((W+1)'(0) - den_ext) : den_ext;

    logic last_iter;
    assign last_iter = (cnt == CW'(W - 1));

    // Correction: restore the sign, then add the sign-extended remainder at full width.
    logic [AW-1:0] prod_s;
    logic [AW-1:0] res_sext;
    logic [W-1:0]  num_calc;
    assign prod_s   = sign_r ? (AW'(0) - acc) : acc;
    assign res_sext = {{(AW - W){res_r[W-1]}}, res_r};

`ifdef MULT_OVF_EN
    logic [AW-1:0] full;
    logic          ovf_calc;
    assign full     = prod_s + res_sext;
    assign num_calc = full[W-1:0];
    // In range only if every bit from the result sign bit upward is identical.
    assign ovf_calc = ~((&full[AW-1:W-1]) | ~(|full[AW-1:W-1]));
`else
    assign num_calc = W'(prod_s + res_sext);
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = MUL;
            MUL:     if (last_iter) state_next = CORR;
            CORR:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mcand  <= '0;
            mplier <= '0;
            res_r  <= '0;
            sign_r <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            NUM    <= '0;
            DONE   <= 1'b0;
`ifdef MULT_OVF_EN
            OVF    <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        mcand  <= {{(W + 1){1'b0}}, coc_mag};
                        mplier <= den_mag;
                        res_r  <= RES;
                        sign_r <= COC[W-1] ^ DEN[W-1];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                CORR: begin
                    NUM  <= num_calc;
                    DONE <= 1'b1;
`ifdef MULT_OVF_EN
                    OVF  <= ovf_calc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// tb/tb_multiplicador_algoritmico.sv - directed self-checking bench for multiplicador_algoritmico

module tb_multiplicador_algoritmico;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] coc, den, res;
    logic [31:0] num;
    logic        done;
`ifdef MULT_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    int pulses;

    multiplicador_algoritmico #(.tamanyo(32)) dut (
        .CLK   (clk),
        .RSTn  (rst_n),
        .START (start),
        .COC   (coc),
        .DEN   (den),
        .RES   (res),
        .NUM   (num),
        .DONE  (done)
`ifdef MULT_OVF_EN
        ,
        .OVF   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Drives one START on the next edge; returns #1 after that edge.
    task automatic start_op(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r);
        coc   = c;
        den   = d;
        res   = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the START-sampling edge until DONE is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) p++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        coc   = '0;
        den   = '0;
        res   = '0;
        #1;
        check("reset_num", num, 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed mix with exact latency and single-cycle pulse
        start_op(32'(-3), 32'd489659762, 32'(-181512305));
        wait_done(lat);
        check("mix_latency", 32'(lat), 32'd33);
        check("mix_num", num, 32'(-1650491591));
        @(posedge clk);
        #1;
        check("mix_pulse_width", 32'(done), 32'd0);
        check("mix_num_hold", num, 32'(-1650491591));

        // Asynchronous reset with no clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_num", num, 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero operand still runs the full count
        start_op(32'd0, 32'd1810121551, 32'(-785348031));
        wait_done(lat);
        check("zero_latency", 32'(lat), 32'd33);
        check("zero_num", num, 32'(-785348031));

        // Extreme operand
        start_op(32'h8000_0000, 32'd1, 32'd0);
        wait_done(lat);
        check("min_num", num, 32'h8000_0000);
`ifdef MULT_OVF_EN
        check("min_ovf", 32'(ovf), 32'd0);
`endif
        start_op(32'(-1), 32'(-1), 32'(-1));
        wait_done(lat);
        check("neg1_num", num, 32'd0);

        // Wraparound
        start_op(32'd65536, 32'd65536, 32'd5);
        wait_done(lat);
        check("wrap_num", num, 32'd5);
`ifdef MULT_OVF_EN
        check("wrap_ovf", 32'(ovf), 32'd1);
`endif

        // START during MUL is ignored and input changes do not leak in
        start_op(32'd100, 32'(-7), 32'd11);
        repeat (4) @(posedge clk);
        #1;
        coc   = 32'd7;
        den   = 32'd7;
        res   = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        coc   = 32'd12345;
        den   = 32'd999;
        res   = 32'd77;
        lat   = 5;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_latency", 32'(lat), 32'd33);
        check("busy_num", num, 32'(-689));
        count_pulses(40, pulses);
        check("busy_no_second_done", 32'(pulses), 32'd0);

        // START held high across DONE restarts on the pulse cycle
        coc   = 32'd5;
        den   = 32'd6;
        res   = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("held_first_latency", 32'(lat), 32'd33);
        check("held_first_num", num, 32'd31);
        coc = 32'(-4);
        den = 32'd9;
        res = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("held_second_latency", 32'(lat), 32'd33);
        check("held_second_num", num, 32'(-34));

        // Reset mid-operation abandons the result
        start_op(32'd1000, 32'd1000, 32'd1);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_num", num, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_pulses(40, pulses);
        check("midrst_no_done", 32'(pulses), 32'd0);
        check("midrst_num_after", num, 32'd0);
        start_op(32'd12, 32'(-12), 32'd3);
        wait_done(lat);
        check("after_rst_latency", 32'(lat), 32'd33);
        check("after_rst_num", num, 32'(-141));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
